dac_sample_feeder: RTL

//  Upstream pacing stage for the QDR LVDS DAC serializer.
//  - Accepts 14-bit samples over a valid/ready stream and buffers them in a FIFO.
//  - Presents one sample on data_out every WORD_CYCLES clocks; data_out drives the serializer's data_in.
//  - Handles startup priming, underflow substitution and controlled stop.

---
 rtl/dac_sample_feeder_if.sv | 11 +
 rtl/dac_sample_feeder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dac_sample_feeder_if.sv
// Sample stream into the DAC pacing stage: valid/ready handshake carrying one DAC code per beat.
interface dac_sample_feeder_if #(
    parameter int DATA_W = 14
) ();
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dac_sample_feeder.sv
// Paces buffered samples onto the serializer data bus, one word per WORD_CYCLES clocks,
// with FIFO priming, underflow substitution and slot-aligned stop.
module dac_sample_feeder #(
    parameter int                DATA_W         = 14,
    parameter int                WORD_CYCLES    = 8,
    parameter int                FIFO_DEPTH     = 16,
    parameter int                PRIME_LEVEL    = 4,
    parameter logic [DATA_W-1:0] IDLE_CODE      = 14'h2000,
    parameter int                UNDERFLOW_MODE = 0,
    localparam int               LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    dac_sample_feeder_if.slave  s,
    input  logic                enable,
    input  logic                flush,
    input  logic                clear_err,
    output logic [DATA_W-1:0]   data_out,
    output logic                word_strobe,
    output logic                running,
    output logic [LVL_W-1:0]    fifo_level,
    output logic                underflow,
    output logic [15:0]         underflow_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WORD_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              strobe_q, strobe_d;
    logic              uf_q, uf_d;
    logic [15:0]       ufcnt_q, ufcnt_d;
    logic              stop_q, stop_d;
    logic              full, empty, push, pop, do_flush;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign full      = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty     = (level_q == '0);
    assign s.s_ready = !full;
    assign push      = s.s_valid && !full;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        uf_d     = uf_q;
        ufcnt_d  = ufcnt_q;
        stop_d   = stop_q;
        pop      = 1'b0;
        do_flush = 1'b0;
        if (clear_err) begin
            uf_d    = 1'b0;
            ufcnt_d = 16'd0;
        end
        case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                stop_d   = 1'b0;
                do_flush = flush;
                if (enable) state_d = S_PRIME;
            end
            S_PRIME: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (level_q >= LVL_W'(PRIME_LEVEL)) begin
                    pop      = 1'b1;
                    data_d   = mem[rd_ptr_q];
                    strobe_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // A stop request made anywhere in the slot is remembered until the slot ends.
                if (!enable) stop_d = 1'b1;
                if (cnt_q == CW'(WORD_CYCLES - 1)) begin
                    cnt_d    = '0;
                    strobe_d = 1'b1;
                    if (stop_q || !enable) begin
                        data_d  = IDLE_CODE;
                        stop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (!empty) begin
                        pop    = 1'b1;
                        data_d = mem[rd_ptr_q];
                    end else begin
                        if (UNDERFLOW_MODE != 0) data_d = IDLE_CODE;
                        uf_d    = 1'b1;
                        // A same-cycle clear restarts the count at this underflow.
                        ufcnt_d = clear_err ? 16'd1 : sat_inc(ufcnt_q);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_flush) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = LVL_W'(push);
        end else begin
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= s.s_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= IDLE_CODE;
            strobe_q <= 1'b0;
            uf_q     <= 1'b0;
            ufcnt_q  <= 16'd0;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            uf_q     <= uf_d;
            ufcnt_q  <= ufcnt_d;
            stop_q   <= stop_d;
        end
    end

    assign data_out      = data_q;
    assign word_strobe   = strobe_q;
    assign running       = (state_q == S_RUN);
    assign fifo_level    = level_q;
    assign underflow     = uf_q;
    assign underflow_cnt = ufcnt_q;
endmodule
